// File: rtl/fpu_wb_arbiter_pkg.sv
// Shared definitions for the FPU writeback arbiter: sizing, source indices
// and the queued writeback entry format.
package fpu_wb_arbiter_pkg;

    localparam int NSRC  = 14;
    localparam int DEPTH = 4;

    // Upper lane sources are even, lower lane sources are odd.
    localparam int SRC_FADD_U  = 0;
    localparam int SRC_FADD_L  = 1;
    localparam int SRC_FSUB_U  = 2;
    localparam int SRC_FSUB_L  = 3;
    localparam int SRC_FMUL_U  = 4;
    localparam int SRC_FMUL_L  = 5;
    localparam int SRC_FDIV_U  = 6;
    localparam int SRC_FDIV_L  = 7;
    localparam int SRC_FSQRT_U = 8;
    localparam int SRC_FSQRT_L = 9;
    localparam int SRC_FTOI_U  = 10;
    localparam int SRC_FTOI_L  = 11;
    localparam int SRC_ITOF_U  = 12;
    localparam int SRC_ITOF_L  = 13;

    typedef struct packed {
        logic [4:0]  rt;
        logic [31:0] tdata;
    } wb_entry_t;

endpackage

// File: rtl/fpu_wb_arbiter_src_fifo.sv
// Per-source result queue with occupancy count. A push into a full queue is
// accepted only when the head is popped at the same edge.
module fpu_wb_arbiter_src_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               push,
    input  fpu_wb_arbiter_pkg::wb_entry_t      din,
    input  logic                               pop,
    output fpu_wb_arbiter_pkg::wb_entry_t      head,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               full,
    output logic                               empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fpu_wb_arbiter_pkg::wb_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; count/pointers alone decide what is valid,
    // which lets the array map onto plain RAM/flop arrays without reset muxes.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Collects results from all FPU units into per-source queues and retires up
// to two per cycle onto the upper/lower writeback ports, round-robin.
module fpu_wb_arbiter #(
    parameter int NSRC  = fpu_wb_arbiter_pkg::NSRC,
    parameter int DEPTH = fpu_wb_arbiter_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC-1:0][31:0] src_tdata,
    input  logic [NSRC-1:0][4:0]  src_rt,
    output logic                  wb_u_valid,
    output logic [4:0]            wb_u_rt,
    output logic [31:0]           wb_u_tdata,
    output logic                  wb_l_valid,
    output logic [4:0]            wb_l_rt,
    output logic [31:0]           wb_l_tdata,
    output logic                  stall_req,
    output logic                  overflow
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int RRW = $clog2(NSRC);

    fpu_wb_arbiter_pkg::wb_entry_t din_vec [NSRC];
    fpu_wb_arbiter_pkg::wb_entry_t head    [NSRC];
    logic [CW-1:0]   count [NSRC];
    logic [NSRC-1:0] full;
    logic [NSRC-1:0] empty;
    logic [NSRC-1:0] pop;

    logic [RRW-1:0]  rr;
    logic            gu_ok;
    logic            gl_ok;
    logic [RRW-1:0]  gu_idx;
    logic [RRW-1:0]  gl_idx;
    int              idx;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign din_vec[i] = {src_rt[i], src_tdata[i]};
        fpu_wb_arbiter_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (src_valid[i]),
            .din   (din_vec[i]),
            .pop   (pop[i]),
            .head  (head[i]),
            .count (count[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    function automatic logic [RRW-1:0] next_rr(input logic [RRW-1:0] i);
        return (i == RRW'(NSRC - 1)) ? '0 : i + 1'b1;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path through
    // the loop can leave one unassigned and infer a latch.
    always_comb begin
        gu_ok  = 1'b0;
        gl_ok  = 1'b0;
        gu_idx = '0;
        gl_idx = '0;
        idx    = 0;
        pop    = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!empty[idx]) begin
                if (!gu_ok) begin
                    gu_ok  = 1'b1;
                    gu_idx = RRW'(idx);
                end else if (!gl_ok && head[idx].rt != head[gu_idx].rt) begin
                    // A same-rt head is skipped so one register never gets two writes.
                    gl_ok  = 1'b1;
                    gl_idx = RRW'(idx);
                end
            end
        end
        if (gu_ok) pop[gu_idx] = 1'b1;
        if (gl_ok) pop[gl_idx] = 1'b1;
    end

    always_comb begin
        stall_req = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (count[i] >= CW'(DEPTH - 2)) stall_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr         <= '0;
            wb_u_valid <= 1'b0;
            wb_u_rt    <= '0;
            wb_u_tdata <= '0;
            wb_l_valid <= 1'b0;
            wb_l_rt    <= '0;
            wb_l_tdata <= '0;
            overflow   <= 1'b0;
        end else begin
            wb_u_valid <= gu_ok;
            wb_l_valid <= gl_ok;
            if (gu_ok) begin
                wb_u_rt    <= head[gu_idx].rt;
                wb_u_tdata <= head[gu_idx].tdata;
            end
            if (gl_ok) begin
                wb_l_rt    <= head[gl_idx].rt;
                wb_l_tdata <= head[gl_idx].tdata;
            end
            if (gl_ok)      rr <= next_rr(gl_idx);
            else if (gu_ok) rr <= next_rr(gu_idx);
            if (|(src_valid & full & ~pop)) overflow <= 1'b1;
        end
    end

endmodule
